mem_bridge_ctrl: RTL and testbench

//  MEM-stage access controller between the CPU pipeline, data memory (DM) and two

---
 rtl/mem_bridge_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_bridge_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge_ctrl.sv
// mem_bridge_ctrl: MEM-stage access controller between the CPU pipeline, data
// memory and two word-only timer devices. It decodes the address, raises
// alignment/range exceptions, and drives DM byte enables for sb/sh/sw. Device
// accesses use a req/ack handshake and stall the pipeline until the access is
// done. Load extension is handled downstream.
// Optional feature: define BRIDGE_TIMEOUT_EN to bound the device wait with a
// timeout counter that reports BusErr_M.
module mem_bridge_ctrl #(
    parameter logic [31:0] DM_TOP         = 32'h0000_2FFF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [1:0]  Size_M,
    input  logic [31:0] Addr_M,
    input  logic [31:0] WData_M,
    input  logic        Flush_M,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        dev_req,
    output logic        dev_sel,
    output logic        dev_we,
    output logic [1:0]  dev_addr,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    input  logic        dev_ack,
    output logic [31:0] RData_M,
    output logic        Stall_M,
    output logic        AdEL,
    output logic        AdES,
    output logic        BusErr_M
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_dev_req;
    logic        r_dev_sel;
    logic        r_dev_we;
    logic [1:0]  r_dev_addr;
    logic [31:0] r_dev_wdata;
    logic [31:0] r_rdata;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_buserr;
`endif

    logic        w_access;
    logic        w_store;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_in_dm;
    logic        w_in_dev0;
    logic        w_in_dev1;
    logic        w_in_dev;
    logic        w_misalign;
    logic        w_fault;
    logic        w_active;
    logic        w_exc;
    logic        w_dm_go;
    logic        w_dev_go;
    logic [3:0]  w_be;
    logic [31:0] w_lanes;

    // A simultaneous read and write is treated as a store.
    assign w_access  = MemRead_M | MemWrite_M;
    assign w_store   = MemWrite_M;
    assign w_is_word = Size_M[1];
    assign w_is_half = (Size_M == 2'b01);

    assign w_in_dm   = (Addr_M <= DM_TOP);
    assign w_in_dev0 = (Addr_M >= 32'h0000_7F00) && (Addr_M <= 32'h0000_7F0B);
    assign w_in_dev1 = (Addr_M >= 32'h0000_7F10) && (Addr_M <= 32'h0000_7F1B);
    assign w_in_dev  = w_in_dev0 | w_in_dev1;

    assign w_misalign = (w_is_half & Addr_M[0]) | (w_is_word & (Addr_M[1:0] != 2'b00));
    assign w_fault    = ~(w_in_dm | w_in_dev) | w_misalign | (w_in_dev & ~w_is_word);

    // Only a new instruction in IDLE may act; DONE still holds the previous
    // device instruction, which must not be launched again.
    assign w_active = ~reset & (r_state == S_IDLE) & ~Flush_M & w_access;
    assign w_exc    = w_active & w_fault;
    assign w_dm_go  = w_active & ~w_fault & w_in_dm;
    assign w_dev_go = w_active & ~w_fault & w_in_dev;

    assign AdEL = w_exc & ~w_store;
    assign AdES = w_exc & w_store;

    // Byte-lane enables and lane-replicated store data for sb/sh/sw.
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = WData_M;
        case (Size_M)
            2'b00: begin
                w_be    = 4'b0001 << Addr_M[1:0];
                w_lanes = {4{WData_M[7:0]}};
            end
            2'b01: begin
                w_be    = Addr_M[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{WData_M[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = WData_M;
            end
        endcase
    end

    assign dm_we    = (w_dm_go & w_store) ? w_be : 4'b0000;
    assign dm_addr  = reset ? 32'h0 : {Addr_M[31:2], 2'b00};
    assign dm_wdata = reset ? 32'h0 : w_lanes;

    // DM loads pass straight through; a finished device access shows its captured word.
    assign RData_M = reset               ? 32'h0 :
                     (r_state == S_DONE) ? r_rdata :
                     (r_state == S_IDLE) ? dm_rdata : 32'h0;

    assign Stall_M   = w_dev_go | (r_state == S_WAIT);
    assign dev_req   = r_dev_req;
    assign dev_sel   = r_dev_sel;
    assign dev_we    = r_dev_we;
    assign dev_addr  = r_dev_addr;
    assign dev_wdata = r_dev_wdata;

`ifdef BRIDGE_TIMEOUT_EN
    assign BusErr_M = r_buserr;
`else
    assign BusErr_M = 1'b0;
`endif

    // Device access sequencer: latch the request, hold req until ack (or timeout), show result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dev_req   <= 1'b0;
            r_dev_sel   <= 1'b0;
            r_dev_we    <= 1'b0;
            r_dev_addr  <= 2'b00;
            r_dev_wdata <= 32'h0;
            r_rdata     <= 32'h0;
`ifdef BRIDGE_TIMEOUT_EN
            r_cnt       <= '0;
            r_buserr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dev_go) begin
                        r_dev_sel   <= w_in_dev1;
                        r_dev_we    <= w_store;
                        r_dev_addr  <= Addr_M[3:2];
                        r_dev_wdata <= WData_M;
                        r_dev_req   <= 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Flush_M is deliberately ignored here: a started device access
                    // may already have side effects and must run to completion.
                    if (dev_ack) begin
                        r_rdata   <= dev_rdata;
                        r_dev_req <= 1'b0;
                        r_state   <= S_DONE;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata   <= 32'h0;
                        r_dev_req <= 1'b0;
                        r_buserr  <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
`ifdef BRIDGE_TIMEOUT_EN
                    r_buserr <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_dev_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge_ctrl.sv
// Directed bench for mem_bridge_ctrl: DM byte lanes, exceptions, flush,
// device handshake with a scoreboard of expected device transactions,
// reset during WAIT, and the optional timeout behaviour.
module tb_mem_bridge_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [1:0]  Size_M;
    logic [31:0] Addr_M;
    logic [31:0] WData_M;
    logic        Flush_M;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dev_req;
    logic        dev_sel;
    logic        dev_we;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        dev_ack;
    logic [31:0] RData_M;
    logic        Stall_M;
    logic        AdEL;
    logic        AdES;
    logic        BusErr_M;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    mem_bridge_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .Size_M     (Size_M),
        .Addr_M     (Addr_M),
        .WData_M    (WData_M),
        .Flush_M    (Flush_M),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dev_req    (dev_req),
        .dev_sel    (dev_sel),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_rdata  (dev_rdata),
        .dev_ack    (dev_ack),
        .RData_M    (RData_M),
        .Stall_M    (Stall_M),
        .AdEL       (AdEL),
        .AdES       (AdES),
        .BusErr_M   (BusErr_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        Size_M     = 2'b10;
        Addr_M     = 32'h0;
        WData_M    = 32'h0;
        Flush_M    = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        MemRead_M  = rd;
        MemWrite_M = wr;
        Size_M     = sz;
        Addr_M     = a;
        WData_M    = d;
    endtask

    // Called just after a rising edge with the bridge in IDLE; returns just after
    // the edge that ends DONE, with the bus idle.
    task automatic dev_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_delay, input logic flush_wait);
        exp_t e;
        exp_t h;
        e.sel   = addr[4];
        e.we    = we;
        e.addr  = addr[3:2];
        e.wdata = wdata;
        e.rdata = rdata;
        sb_q.push_back(e);
        drive(~we, we, 2'b10, addr, wdata);
        dev_ack   = 1'b0;
        dev_rdata = 32'hBAD0_BAD0;
        #1;
        chk("idle_stall", 32'(Stall_M), 32'd1);
        chk("idle_req",   32'(dev_req), 32'd0);
        chk("idle_dm_we", 32'(dm_we),   32'd0);
        @(posedge clk); #1;
        if (flush_wait) Flush_M = 1'b1;
        for (int i = 1; i <= ack_delay; i++) begin
            h = sb_q[0];
            chk("wait_req",   32'(dev_req),   32'd1);
            chk("wait_stall", 32'(Stall_M),   32'd1);
            chk("wait_sel",   32'(dev_sel),   32'(h.sel));
            chk("wait_we",    32'(dev_we),    32'(h.we));
            chk("wait_addr",  32'(dev_addr),  32'(h.addr));
            chk("wait_wdata", dev_wdata,      h.wdata);
            if (i == ack_delay) begin
                dev_ack   = 1'b1;
                dev_rdata = rdata;
            end
            @(posedge clk); #1;
            dev_ack   = 1'b0;
            dev_rdata = 32'hBAD0_BAD0;
        end
        h = sb_q.pop_front();
        chk("done_stall",  32'(Stall_M),  32'd0);
        chk("done_req",    32'(dev_req),  32'd0);
        chk("done_rdata",  RData_M,       h.rdata);
        chk("done_buserr", 32'(BusErr_M), 32'd0);
        @(posedge clk); #1;
        bus_idle();
    endtask

    initial begin
        reset     = 1'b1;
        dev_ack   = 1'b0;
        dev_rdata = 32'h0;
        dm_rdata  = 32'h0;
        bus_idle();
        @(posedge clk); @(posedge clk); #1;

        // Outputs held at zero while reset is asserted, even with a store presented
        drive(1'b0, 1'b1, 2'b10, 32'h0000_0100, 32'h1122_3344);
        #1;
        chk("rst_dm_we",    32'(dm_we),    32'd0);
        chk("rst_dm_addr",  dm_addr,       32'd0);
        chk("rst_dm_wdata", dm_wdata,      32'd0);
        chk("rst_stall",    32'(Stall_M),  32'd0);
        chk("rst_req",      32'(dev_req),  32'd0);
        chk("rst_buserr",   32'(BusErr_M), 32'd0);
        drive(1'b1, 1'b0, 2'b10, 32'h0000_7F04, 32'h0);
        #1;
        chk("rst_dev_stall", 32'(Stall_M), 32'd0);
        chk("rst_rdata",     RData_M,      32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_idle();

        // sb into lane 2
        drive(1'b0, 1'b1, 2'b00, 32'h0000_1002, 32'h0000_00AB);
        #1;
        chk("sb_we",    32'(dm_we),   32'h4);
        chk("sb_wdata", dm_wdata,     32'hABAB_ABAB);
        chk("sb_addr",  dm_addr,      32'h0000_1000);
        chk("sb_stall", 32'(Stall_M), 32'd0);
        chk("sb_ades",  32'(AdES),    32'd0);
        @(posedge clk); #1;

        // sh upper half
        drive(1'b0, 1'b1, 2'b01, 32'h0000_1006, 32'h1234_CDEF);
        #1;
        chk("sh_we",    32'(dm_we), 32'hC);
        chk("sh_wdata", dm_wdata,   32'hCDEF_CDEF);
        @(posedge clk); #1;

        // sw at the top word of DM
        drive(1'b0, 1'b1, 2'b10, 32'h0000_2FFC, 32'h8765_4321);
        #1;
        chk("sw_top_we",    32'(dm_we), 32'hF);
        chk("sw_top_wdata", dm_wdata,   32'h8765_4321);
        chk("sw_top_ades",  32'(AdES),  32'd0);
        @(posedge clk); #1;

        // lw from DM passes the read word through
        dm_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h0);
        #1;
        chk("lw_dm_rdata", RData_M,      32'hDEAD_BEEF);
        chk("lw_dm_we",    32'(dm_we),   32'd0);
        chk("lw_dm_stall", 32'(Stall_M), 32'd0);
        @(posedge clk); #1;

        // Misaligned halfword load
        drive(1'b1, 1'b0, 2'b01, 32'h0000_0003, 32'h0);
        #1;
        chk("lh_mis_adel",  32'(AdEL),    32'd1);
        chk("lh_mis_dm_we", 32'(dm_we),   32'd0);
        chk("lh_mis_stall", 32'(Stall_M), 32'd0);
        @(posedge clk); #1;

        // Byte store to a word-only device
        drive(1'b0, 1'b1, 2'b00, 32'h0000_7F10, 32'h55);
        #1;
        chk("sbdev_ades",  32'(AdES),    32'd1);
        chk("sbdev_adel",  32'(AdEL),    32'd0);
        chk("sbdev_stall", 32'(Stall_M), 32'd0);
        @(posedge clk); #1;
        bus_idle();
        #1;
        chk("sbdev_req", 32'(dev_req), 32'd0);

        // Just beyond DM and just beyond timer0 are unmapped
        drive(1'b1, 1'b0, 2'b10, 32'h0000_3000, 32'h0);
        #1;
        chk("unmap_dm_adel", 32'(AdEL), 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 2'b10, 32'h0000_7F0C, 32'h0);
        #1;
        chk("unmap_t0_adel",  32'(AdEL),    32'd1);
        chk("unmap_t0_stall", 32'(Stall_M), 32'd0);
        @(posedge clk); #1;

        // Read and write together counts as a store
        drive(1'b1, 1'b1, 2'b10, 32'h0000_0102, 32'h0);
        #1;
        chk("rw_ades", 32'(AdES), 32'd1);
        chk("rw_adel", 32'(AdEL), 32'd0);
        @(posedge clk); #1;

        // Flush in IDLE blocks a device store
        drive(1'b0, 1'b1, 2'b10, 32'h0000_7F18, 32'hFFFF_0000);
        Flush_M = 1'b1;
        #1;
        chk("flush_stall", 32'(Stall_M), 32'd0);
        chk("flush_ades",  32'(AdES),    32'd0);
        @(posedge clk); #1;
        chk("flush_req1", 32'(dev_req), 32'd0);
        @(posedge clk); #1;
        chk("flush_req2", 32'(dev_req), 32'd0);
        bus_idle();

        // Device load from timer0 register 1, ack on the second WAIT cycle
        dev_access(1'b0, 32'h0000_7F04, 32'h0, 32'h0000_1234, 2, 1'b0);
        // Device store to timer1 register 1, ack on the first WAIT cycle
        dev_access(1'b1, 32'h0000_7F14, 32'hCAFE_F00D, 32'h0000_0077, 1, 1'b0);
        // Flush during WAIT does not abort the access
        dev_access(1'b0, 32'h0000_7F1C - 32'd4, 32'h0, 32'hA5A5_5A5A, 3, 1'b1);

        // Reset while waiting on a device
        drive(1'b1, 1'b0, 2'b10, 32'h0000_7F08, 32'h0);
        #1;
        chk("rstw_stall0", 32'(Stall_M), 32'd1);
        @(posedge clk); #1;
        chk("rstw_req_wait", 32'(dev_req), 32'd1);
        reset = 1'b1;
        bus_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstw_req",    32'(dev_req),  32'd0);
        chk("rstw_stall",  32'(Stall_M),  32'd0);
        chk("rstw_buserr", 32'(BusErr_M), 32'd0);
        dev_access(1'b0, 32'h0000_7F00, 32'h0, 32'h0000_55AA, 3, 1'b0);

`ifdef BRIDGE_TIMEOUT_EN
        // No ack: request held for the full timeout, then a one-cycle bus error
        drive(1'b1, 1'b0, 2'b10, 32'h0000_7F00, 32'h0);
        #1;
        chk("to_stall0", 32'(Stall_M), 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) begin
            chk("to_req",   32'(dev_req), 32'd1);
            chk("to_stall", 32'(Stall_M), 32'd1);
            @(posedge clk); #1;
        end
        chk("to_done_buserr", 32'(BusErr_M), 32'd1);
        chk("to_done_rdata",  RData_M,       32'd0);
        chk("to_done_req",    32'(dev_req),  32'd0);
        chk("to_done_stall",  32'(Stall_M),  32'd0);
        @(posedge clk); #1;
        bus_idle();
        #1;
        chk("to_after_buserr", 32'(BusErr_M), 32'd0);
        // Ack on the last allowed cycle wins over the timeout
        dev_access(1'b0, 32'h0000_7F10, 32'h0, 32'h0BAD_F00D, 16, 1'b0);
`else
        // Without the timeout feature the bridge waits as long as needed
        dev_access(1'b0, 32'h0000_7F10, 32'h0, 32'h0BAD_F00D, 20, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
